ncoin_rx_fifo: RTL and testbench
================================

# ncoin_rx_fifo

Block buffer directly downstream of the RMII frame receiver. Captures each 128-bit payload block and its 48-bit source MAC on the receiver's single-cycle `valid` pulse. Stores them in a small first-word-fall-through FIFO and presents them to the compute core over a valid/ready handshake. Counts blocks dropped on overflow, because the receiver cannot be back-pressured.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `DATA_W`, 128: payload block width.
- `MAC_W`, 48: source MAC width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_W  payload block from the receiver.
- `in_src_mac`  in  MAC_W  source MAC of the frame carrying the block.
- `in_valid`  in  1  single-cycle strobe; `in_data` and `in_src_mac` are valid in the same cycle.
- `out_data`  out  DATA_W  head entry payload.
- `out_src_mac`  out  MAC_W  head entry MAC.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer accepts the head entry.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `drop_cnt`  out  16  blocks dropped on overflow; saturates at 16'hFFFF.
- `clr_drop`  in  1  synchronous clear of `drop_cnt`.

## Operation
- **Storage:** flop array of DEPTH entries, each `{in_src_mac, in_data}`.
  - Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is held as an explicit counter.
- **Pop:** `out_valid && out_ready`. The read pointer advances and `level` decrements.
- **Push:** `in_valid && (!full || pop)`. The entry is written at the write pointer, the pointer advances, and `level` increments.
- **Push and pop in the same cycle:** both happen and `level` is unchanged. This includes the full case, where a pop frees the slot and the incoming block is accepted.
- **Push and pop when empty:** `out_valid` is 0, so no pop occurs; the push alone takes effect.
- **Drop:** `in_valid && full && !pop`. Nothing is written and `drop_cnt` increments unless it is already 16'hFFFF.
- **Clear:** when `clr_drop` is asserted, `drop_cnt` becomes 0.
  - If a drop occurs in the same cycle, `drop_cnt` becomes 1 so the event is not lost.
- **Outputs:**
  - `out_valid` = !empty.
  - `out_data` and `out_src_mac` are the entry at the read pointer.
  - They are held stable while `out_valid && !out_ready`.
  - When empty, they hold the last popped entry.
- **Input rules:**
  - `in_valid` high for consecutive cycles is legal; each cycle is a separate block. The receiver normally spaces blocks 64 cycles apart.
  - `out_ready` may be asserted independently of `out_valid`. `out_ready` while empty has no effect.

## Timing
- **Reset (asynchronous, `rst` low), values immediately and until the first clock after release:**
  - pointers 0, `level` 0, `empty` 1, `full` 0, `out_valid` 0;
  - `out_data` 0, `out_src_mac` 0, `drop_cnt` 0;
  - array contents are also cleared to 0.
- **Reset mid-operation:** all stored entries are discarded and no partial pop is visible. Once reset is released, the next `in_valid` behaves exactly as on an empty FIFO.
- **Latency:** `in_valid` sampled at edge N into an empty FIFO gives `out_valid` = 1 and `out_data` = that block in the cycle after edge N, i.e. 1 cycle.
- **Pop timing:** a pop at edge M presents the next entry, or `out_valid` = 0, in the cycle after edge M.
- **Status timing:** `full`, `empty` and `level` are registered state. They update on the same edge as the pointers.
- **Drop counter timing:** `drop_cnt` updates on the edge where the drop or clear is sampled.

## Test plan
- **Reset values:** hold `rst` low with random inputs, then release -> all outputs at their reset values; `empty` = 1, `level` = 0.
- **Single block:** push `in_data` = 128'h0123…CDEF with `in_src_mac` = 48'h02_00_00_00_00_01 and `out_ready` = 0 -> one cycle later `out_valid` = 1 with that data and MAC. Hold `out_ready` = 0 for 10 cycles -> outputs unchanged. Pulse `out_ready` -> `out_valid` = 0 and `empty` = 1.
- **Overflow:** DEPTH = 4 with `out_ready` = 0. Push blocks 1..6 -> `full` = 1 after block 4 and `drop_cnt` = 2. Then drain with `out_ready` = 1 -> blocks 1, 2, 3, 4 appear in order.
- **Push and pop while full:** with the FIFO full, assert `in_valid` and `out_ready` in the same cycle -> block accepted, `level` stays 4, `drop_cnt` unchanged. It reads out last, after the 3 remaining older entries.
- **Counter saturation and clear:** force 65,537 drops -> `drop_cnt` = 16'hFFFF. Assert `clr_drop` together with a drop -> `drop_cnt` = 1. Assert `clr_drop` alone -> `drop_cnt` = 0.
- **Reset mid-operation and wrap:** push 3 blocks, pull `rst` low mid-cycle -> outputs go to reset values immediately. After release, push and pop 9 blocks back to back so the pointers wrap twice -> data order preserved and `level` never exceeds 1.

Source files
------------

// File: rtl/ncoin_rx_fifo.sv
// First-word-fall-through block buffer between the RMII frame receiver and the compute core.
// Stores {src_mac, data} entries and counts blocks dropped when the FIFO is full.
module ncoin_rx_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned MAC_W  = 48
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [MAC_W-1:0]         in_src_mac,
   input  logic                     in_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [MAC_W-1:0]         out_src_mac,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              drop_cnt,
   input  logic                     clr_drop
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned EW = DATA_W + MAC_W;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic          push, pop, drop;
   logic [AW-1:0] out_ptr;
   logic [EW-1:0] head;

   assign full      = (level_q == LW'(DEPTH));
   assign empty     = (level_q == '0);
   assign out_valid = !empty;
   assign level     = level_q;
   assign drop_cnt  = drop_cnt_q;

   assign pop  = out_valid && out_ready;
   assign push = in_valid && (!full || pop);
   assign drop = in_valid && full && !pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      drop_cnt_d = drop_cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      // A drop coinciding with a clear is counted so the event is not lost.
      if (clr_drop) begin
         drop_cnt_d = drop ? 16'd1 : 16'd0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         drop_cnt_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         drop_cnt_q <= drop_cnt_d;
         if (push) mem_q[wr_ptr_q] <= {in_src_mac, in_data};
      end
   end

   // When empty, the slot behind the read pointer still holds the last popped entry.
   always_comb begin
      out_ptr = empty ? (rd_ptr_q - AW'(1)) : rd_ptr_q;
      head    = mem_q[out_ptr];
   end

   assign out_data    = head[DATA_W-1:0];
   assign out_src_mac = head[EW-1:DATA_W];

endmodule

// File: tb/tb_ncoin_rx_fifo.sv
// Bench for ncoin_rx_fifo: scoreboard queue of expected entries plus a table of
// overflow/drain vectors and hand-written corner-case sequences.
module tb_ncoin_rx_fifo;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [127:0]  in_data;
   logic [47:0]   in_src_mac;
   logic          in_valid;
   logic [127:0]  out_data;
   logic [47:0]   out_src_mac;
   logic          out_valid;
   logic          out_ready;
   logic          full;
   logic          empty;
   logic [LW-1:0] level;
   logic [15:0]   drop_cnt;
   logic          clr_drop;

   ncoin_rx_fifo #(.DEPTH(DEPTH), .DATA_W(128), .MAC_W(48)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_src_mac  (in_src_mac),
      .in_valid    (in_valid),
      .out_data    (out_data),
      .out_src_mac (out_src_mac),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .full        (full),
      .empty       (empty),
      .level       (level),
      .drop_cnt    (drop_cnt),
      .clr_drop    (clr_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          iv;
      logic          rdy;
      logic [LW-1:0] lvl;
      logic [15:0]   drp;
   } vec_t;

   int unsigned   total = 0;
   int unsigned   bad   = 0;
   logic [175:0]  sb[$];
   logic [175:0]  last;
   logic [15:0]   mdrop;
   vec_t          tbl [10];

   task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] blk(input int k);
      logic [7:0] b;
      b = 8'(k);
      return {16{b}};
   endfunction

   function automatic logic [47:0] mac(input int k);
      return {40'h02_00_00_00_00, 8'(k)};
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, " out_valid"}, 176'(out_valid), 176'(0));
      chk({tag, " empty"},     176'(empty),     176'(1));
      chk({tag, " full"},      176'(full),      176'(0));
      chk({tag, " level"},     176'(level),     176'(0));
      chk({tag, " drop_cnt"},  176'(drop_cnt),  176'(0));
      chk({tag, " out_entry"}, {out_src_mac, out_data}, 176'(0));
   endtask

   // One clock: model the cycle, drive inputs, clock, then compare the DUT against the model.
   task automatic cyc(input logic iv, input logic [127:0] d, input logic [47:0] m,
                      input logic rdy, input logic clr);
      logic p, dr;
      in_valid   = iv;
      in_data    = d;
      in_src_mac = m;
      out_ready  = rdy;
      clr_drop   = clr;
      p  = rdy && (sb.size() != 0);
      dr = iv && (sb.size() == DEPTH) && !p;
      if (p) last = sb.pop_front();
      if (iv && !dr) sb.push_back({m, d});
      if (clr) mdrop = dr ? 16'd1 : 16'd0;
      else if (dr && (mdrop != 16'hFFFF)) mdrop = mdrop + 16'd1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clr_drop  = 1'b0;
      chk("level",     176'(level),     176'(sb.size()));
      chk("empty",     176'(empty),     176'(sb.size() == 0));
      chk("full",      176'(full),      176'(sb.size() == DEPTH));
      chk("out_valid", 176'(out_valid), 176'(sb.size() != 0));
      chk("drop_cnt",  176'(drop_cnt),  176'(mdrop));
      chk("out_entry", {out_src_mac, out_data}, (sb.size() != 0) ? sb[0] : last);
   endtask

   initial begin
      logic [127:0] d1;
      logic [47:0]  m1;

      for (int i = 0; i < 10; i++) begin
         tbl[i].iv  = (i < 6);
         tbl[i].rdy = (i >= 6);
         tbl[i].lvl = (i < 6) ? LW'((i < 3) ? i + 1 : 4) : LW'(9 - i);
         tbl[i].drp = (i >= 4 && i < 6) ? 16'(i - 3) : ((i >= 6) ? 16'd2 : 16'd0);
      end

      sb.delete();
      last      = '0;
      mdrop     = '0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_src_mac = '0;
      out_ready = 1'b0;
      clr_drop  = 1'b0;

      // Reset held low with random inputs
      #1;
      chk_reset_vals("rst_async");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid   = 1'($urandom);
         in_data    = {$urandom, $urandom, $urandom, $urandom};
         in_src_mac = {16'($urandom), $urandom};
         out_ready  = 1'($urandom);
         clr_drop   = 1'($urandom);
         @(posedge clk);
         #1;
         chk_reset_vals("rst_held");
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clr_drop  = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_vals("rst_release");

      // Single block, held for 10 cycles, then popped
      d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
      m1 = 48'h02_00_00_00_00_01;
      cyc(1'b1, d1, m1, 1'b0, 1'b0);
      chk("single_data", 176'(out_data), 176'(d1));
      chk("single_mac",  176'(out_src_mac), 176'(m1));
      for (int i = 0; i < 10; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("single_popped_empty", 176'(empty), 176'(1));

      // Overflow and drain, table driven
      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].iv, blk(i + 1), mac(i + 1), tbl[i].rdy, 1'b0);
         chk("tbl_level", 176'(level),    176'(tbl[i].lvl));
         chk("tbl_drop",  176'(drop_cnt), 176'(tbl[i].drp));
      end

      // Push and pop while full: new block accepted and read out last
      for (int i = 0; i < 4; i++) cyc(1'b1, blk(16 + i), mac(16 + i), 1'b0, 1'b0);
      cyc(1'b1, blk(32), mac(32), 1'b1, 1'b0);
      chk("full_pp_level", 176'(level),    176'(4));
      chk("full_pp_drop",  176'(drop_cnt), 176'(2));
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("full_pp_last", 176'(out_data), 176'(blk(32)));
      cyc(1'b0, '0, '0, 1'b1, 1'b0);

      // Saturation and clear
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cyc(1'b1, blk(40 + i), mac(40 + i), 1'b0, 1'b0);
      for (int i = 0; i < 65537; i++) cyc(1'b1, blk(i), mac(i), 1'b0, 1'b0);
      chk("sat_value", 176'(drop_cnt), 176'(16'hFFFF));
      cyc(1'b1, blk(1), mac(1), 1'b0, 1'b1);
      chk("clr_with_drop", 176'(drop_cnt), 176'(1));
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      chk("clr_alone", 176'(drop_cnt), 176'(0));

      // Reset mid-operation
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, blk(50 + i), mac(50 + i), 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk_reset_vals("rst_mid");
      sb.delete();
      last  = '0;
      mdrop = '0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_vals("rst_mid_release");

      // Back-to-back push/pop of 9 blocks: pointers wrap twice
      for (int i = 0; i < 9; i++) begin
         cyc(1'b1, blk(60 + i), mac(60 + i), 1'b1, 1'b0);
         chk("wrap_level_le1", 176'(level <= LW'(1)), 176'(1));
      end
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("wrap_end_data", 176'(out_data), 176'(blk(68)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
